freq_meter: RTL and testbench



---
 rtl/freq_meter_if.sv | 13 +
 rtl/freq_meter.sv | 91 +++++++++
 tb/tb_freq_meter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meter_if.sv
// Measurement-side signals of freq_meter: the asynchronous input and the published result.
interface freq_meter_if #(
  parameter int unsigned CNT_W = 24
);
  logic             sig_in;
  logic [CNT_W-1:0] freq_out;
  logic             valid;
  logic             ovf;
  logic             gate;

  modport master (output sig_in, input freq_out, input valid, input ovf, input gate);
  modport slave  (input sig_in, output freq_out, output valid, output ovf, output gate);
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over
// back-to-back windows of FREQ clock cycles and publishes each total with a strobe.
module freq_meter #(
  parameter int unsigned FREQ  = 25175000,
  parameter int unsigned CNT_W = 24
) (
  input  logic        mclk_i,
  input  logic        nrst_i,
  freq_meter_if.slave meas
);
  localparam int unsigned      GW        = $clog2(FREQ);
  localparam logic [GW-1:0]    GATE_LAST = GW'(FREQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {SETTLE, MEASURE} state_e;

  state_e           state_q;
  logic             settle_q;
  logic             s1_q, s2_q, s3_q;
  logic [GW-1:0]    gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             sat_q;
  logic [CNT_W-1:0] freq_q;
  logic             valid_q;
  logic             ovf_q;
  logic             gate_q;

  logic edge_c;
  logic at_max_c;
  logic win_end_c;

  always_comb begin
    edge_c    = (state_q == MEASURE) && s2_q && !s3_q;
    at_max_c  = (edge_cnt_q == CNT_MAX);
    win_end_c = (state_q == MEASURE) && (gate_cnt_q == GATE_LAST);
  end

  always_ff @(posedge mclk_i) begin
    if (!nrst_i) begin
      state_q    <= SETTLE;
      settle_q   <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      gate_q     <= 1'b0;
    end else begin
      s1_q    <= meas.sig_in;
      s2_q    <= s1_q;
      valid_q <= 1'b0;
      if (state_q == SETTLE) begin
        // Preload s3 with the level s2 is about to take, so a level already high
        // when MEASURE starts is never mistaken for a rising edge.
        s3_q     <= s1_q;
        settle_q <= 1'b1;
        if (settle_q) begin
          state_q <= MEASURE;
          gate_q  <= 1'b1;
        end
      end else begin
        s3_q <= s2_q;
        if (win_end_c) begin
          gate_cnt_q <= '0;
          freq_q     <= (edge_c && !at_max_c) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
          ovf_q      <= sat_q | (edge_c & at_max_c);
          valid_q    <= 1'b1;
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
        end else begin
          gate_cnt_q <= gate_cnt_q + GW'(1);
          // Saturating count; sat marks that at least one edge was dropped.
          if (edge_c) begin
            if (at_max_c) sat_q <= 1'b1;
            else          edge_cnt_q <= edge_cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign meas.freq_out = freq_q;
  assign meas.valid    = valid_q;
  assign meas.ovf      = ovf_q;
  assign meas.gate     = gate_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 24-bit instance and a 4-bit instance share
// one stimulus; expected counts are worked out by hand from the input pattern.
module tb_freq_meter;
  localparam int unsigned FREQ = 100;
  localparam int unsigned W    = 24;
  localparam int unsigned WO   = 4;

  logic clk = 1'b0;
  logic nrst;
  logic sig;

  always #5 clk = ~clk;

  freq_meter_if #(.CNT_W(W))  bus   ();
  freq_meter_if #(.CNT_W(WO)) bus_o ();

  assign bus.sig_in   = sig;
  assign bus_o.sig_in = sig;

  freq_meter #(.FREQ(FREQ), .CNT_W(W))  u_dut (.mclk_i(clk), .nrst_i(nrst), .meas(bus));
  freq_meter #(.FREQ(FREQ), .CNT_W(WO)) u_ovf (.mclk_i(clk), .nrst_i(nrst), .meas(bus_o));

  typedef struct {
    int          n;
    logic        valid;
    logic [31:0] freq;
    logic        ovf;
    logic        gate;
  } vec_t;

  localparam int NV = 9;
  vec_t nom [NV];

  int   checks;
  int   failures;
  int   n;
  int   gen_per;
  int   gen_ph;
  logic gen_lvl;
  int   rises;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (n=%0d)", name, act, exp, n);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after posedge, then drive next input.
  task automatic tick();
    logic prev;
    @(posedge clk);
    #1;
    n++;
    prev = sig;
    if (gen_per != 0) begin
      sig = ((gen_ph % gen_per) >= (gen_per / 2)) ? 1'b1 : 1'b0;
      gen_ph++;
    end else begin
      sig = gen_lvl;
    end
    if (sig && !prev) rises++;
  endtask

  task automatic do_reset(input int cycles, input logic lvl);
    nrst    = 1'b0;
    gen_per = 0;
    gen_lvl = lvl;
    sig     = lvl;
    repeat (cycles) tick();
  endtask

  // Release reset; the value driven here is the one sampled at cycle 0.
  task automatic release_rst(input int per, input logic lvl);
    nrst    = 1'b1;
    n       = 0;
    rises   = 0;
    gen_per = per;
    gen_lvl = lvl;
    gen_ph  = 0;
    if (per != 0) begin
      sig    = (0 >= (per / 2)) ? 1'b1 : 1'b0;
      gen_ph = 1;
    end else begin
      sig = lvl;
    end
  endtask

  function automatic logic exp_valid_at(input int cyc);
    return (cyc >= 102) && (((cyc - 2) % 100) == 0);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stray;
    int nwin;
    int sum;
    int win [8];

    checks   = 0;
    failures = 0;
    n        = 0;
    rises    = 0;

    nom[0] = '{1,   1'b0, 32'd0,  1'b0, 1'b0};
    nom[1] = '{2,   1'b0, 32'd0,  1'b0, 1'b1};
    nom[2] = '{101, 1'b0, 32'd0,  1'b0, 1'b1};
    nom[3] = '{102, 1'b1, 32'd10, 1'b0, 1'b1};
    nom[4] = '{103, 1'b0, 32'd10, 1'b0, 1'b1};
    nom[5] = '{150, 1'b0, 32'd10, 1'b0, 1'b1};
    nom[6] = '{202, 1'b1, 32'd10, 1'b0, 1'b1};
    nom[7] = '{203, 1'b0, 32'd10, 1'b0, 1'b1};
    nom[8] = '{302, 1'b1, 32'd10, 1'b0, 1'b1};

    // Reset held while the input toggles: every output stays at 0.
    nrst    = 1'b0;
    sig     = 1'b0;
    gen_per = 2;
    gen_ph  = 0;
    gen_lvl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_freq",  32'(bus.freq_out), 32'd0);
      chk("rst_valid", 32'(bus.valid),    32'd0);
      chk("rst_ovf",   32'(bus.ovf),      32'd0);
      chk("rst_gate",  32'(bus.gate),     32'd0);
    end
    gen_per = 0;
    release_rst(0, 1'b0);
    tick();
    chk("rel_gate_c1", 32'(bus.gate), 32'd0);
    tick();
    chk("rel_gate_c2", 32'(bus.gate), 32'd1);

    // Nominal rate: period 10, rises at j = 5 mod 10 -> 10 per window.
    do_reset(2, 1'b0);
    release_rst(10, 1'b0);
    stray = 0;
    for (int i = 0; i < NV; i++) begin
      while (n < nom[i].n) begin
        tick();
        if (bus.valid !== exp_valid_at(n)) stray++;
      end
      chk("nom_valid", 32'(bus.valid),    32'(nom[i].valid));
      chk("nom_freq",  32'(bus.freq_out), nom[i].freq);
      chk("nom_ovf",   32'(bus.ovf),      32'(nom[i].ovf));
      chk("nom_gate",  32'(bus.gate),     32'(nom[i].gate));
    end
    chk("nom_valid_timing", 32'(stray), 32'd0);

    // Input high through reset and settle: no phantom edge.
    do_reset(3, 1'b1);
    release_rst(0, 1'b1);
    while (n < 102) tick();
    chk("nofalse_valid", 32'(bus.valid),    32'd1);
    chk("nofalse_freq",  32'(bus.freq_out), 32'd0);

    // Maximum rate with a one-cycle phase slip in window 3, then input stops.
    do_reset(2, 1'b0);
    release_rst(2, 1'b0);
    nwin = 0;
    sum  = 0;
    while (n < 602) begin
      tick();
      if (n == 250) gen_ph++;
      if (n == 450) gen_per = 0;
      if (bus.valid === 1'b1) begin
        if (nwin < 8) win[nwin] = int'(bus.freq_out);
        nwin++;
        sum += int'(bus.freq_out);
      end
    end
    chk("max_nwin", 32'(nwin), 32'd6);
    chk("max_win1", 32'(win[0]), 32'd50);
    chk("max_win2", 32'(win[1]), 32'd50);
    chk("max_win4", 32'(win[3]), 32'd50);
    chk("max_win6", 32'(win[5]), 32'd0);
    chk("max_sum_vs_edges", 32'(sum), 32'(rises));

    // Overflow: 25 edges into a 4-bit counter, then period 20 from j=100.
    do_reset(2, 1'b0);
    release_rst(4, 1'b0);
    while (n < 102) begin
      tick();
      if (n == 99) begin
        gen_per = 20;
        gen_ph  = 0;
      end
    end
    chk("ovf_w1_valid",  32'(bus_o.valid),    32'd1);
    chk("ovf_w1_freq",   32'(bus_o.freq_out), 32'd15);
    chk("ovf_w1_ovf",    32'(bus_o.ovf),      32'd1);
    chk("ovf_w1_wide",   32'(bus.freq_out),   32'd25);
    chk("ovf_w1_wideov", 32'(bus.ovf),        32'd0);
    while (n < 150) tick();
    chk("ovf_hold", 32'(bus_o.ovf), 32'd1);
    while (n < 202) tick();
    chk("ovf_w2_valid", 32'(bus_o.valid),    32'd1);
    chk("ovf_w2_freq",  32'(bus_o.freq_out), 32'd5);
    chk("ovf_w2_ovf",   32'(bus_o.ovf),      32'd0);
    chk("ovf_w2_wide",  32'(bus.freq_out),   32'd5);

    // One-cycle reset at gate count 50 of window 2.
    do_reset(2, 1'b0);
    release_rst(10, 1'b0);
    while (n < 152) tick();
    chk("mid_pre_freq", 32'(bus.freq_out), 32'd10);
    nrst = 1'b0;
    tick();
    chk("mid_freq",  32'(bus.freq_out), 32'd0);
    chk("mid_valid", 32'(bus.valid),    32'd0);
    chk("mid_ovf",   32'(bus.ovf),      32'd0);
    chk("mid_gate",  32'(bus.gate),     32'd0);
    nrst  = 1'b1;
    n     = 0;
    stray = 0;
    while (n < 101) begin
      tick();
      if (bus.valid !== 1'b0) stray++;
    end
    chk("mid_no_early_valid", 32'(stray), 32'd0);
    tick();
    chk("mid_valid_102", 32'(bus.valid),    32'd1);
    chk("mid_freq_102",  32'(bus.freq_out), 32'd10);
    chk("mid_ovf_102",   32'(bus.ovf),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
